// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC and instruction register, handshakes with
// instruction and data memory, and emits a one-cycle commit strobe per retired instruction.
module instruction_sequencer #(
  parameter int unsigned          PC_WIDTH    = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned          MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_req,
  input  logic                imem_ready,
  input  logic [15:0]         imem_data,
  output logic [15:0]         instruction,
  input  logic                jump_valid,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic                mem_req,
  input  logic                mem_ack,
  output logic                commit,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         retired,
  output logic [2:0]          state,
  output logic                halted,
  output logic                fault
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_COMMIT = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [15:0]         instr_q;
  logic [15:0]         retired_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                imem_req_q, mem_req_q, commit_q, halted_q, fault_q;
  logic                is_mem_c;
  logic [CNT_W-1:0]    cnt_inc_c;

  assign is_mem_c  = (instr_q[15:12] == 4'h0) && instr_q[11];
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Next-state selection; outputs below are registered from this value.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = is_mem_c ? S_MEM : S_COMMIT;
      S_MEM: begin
        if (mem_ack) begin
          state_d = S_COMMIT;
        end else if (cnt_inc_c == TIMEOUT_C) begin
          state_d = S_FAULT;
        end
      end
      S_COMMIT: state_d = run ? S_FETCH : S_IDLE;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      retired_q  <= 16'h0000;
      cnt_q      <= '0;
      imem_req_q <= 1'b0;
      mem_req_q  <= 1'b0;
      commit_q   <= 1'b0;
      halted_q   <= 1'b1;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      imem_req_q <= (state_d == S_FETCH);
      mem_req_q  <= (state_d == S_MEM);
      commit_q   <= (state_d == S_COMMIT);
      halted_q   <= (state_d == S_IDLE);
      fault_q    <= fault_q | (state_d == S_FAULT);

      if (state_q == S_FETCH && imem_ready) begin
        instr_q <= imem_data;
      end

      if (state_q == S_EXEC) begin
        cnt_q <= '0;
      end else if (state_q == S_MEM && !mem_ack) begin
        cnt_q <= cnt_inc_c;
      end

      // Retire: redirect or advance the PC, both wrapping modulo 2^PC_WIDTH.
      if (state_q == S_COMMIT) begin
        pc_q      <= jump_valid ? jump_target : pc_q + PC_WIDTH'(1);
        retired_q <= retired_q + 16'd1;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign imem_req    = imem_req_q;
  assign instruction = instr_q;
  assign mem_req     = mem_req_q;
  assign commit      = commit_q;
  assign pc          = pc_q;
  assign retired     = retired_q;
  assign state       = 3'(state_q);
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with hand-computed expectations (MEM_TIMEOUT=4).
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, imem_ready, jump_valid, mem_ack;
  logic [15:0] imem_data, jump_target;
  logic [15:0] imem_addr, instruction, pc, retired;
  logic        imem_req, mem_req, commit, halted, fault;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  instruction_sequencer #(
    .PC_WIDTH(16), .RESET_PC(16'h0000), .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ready(imem_ready), .imem_data(imem_data),
    .instruction(instruction), .jump_valid(jump_valid), .jump_target(jump_target),
    .mem_req(mem_req), .mem_ack(mem_ack), .commit(commit), .pc(pc), .retired(retired),
    .state(state), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; imem_data = 16'h0000;
    jump_valid = 1'b0; jump_target = 16'h0000; mem_ack = 1'b0;
    step(); step();

    // Reset state
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_instr", 32'(instruction), 32'h0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_commit", 32'(commit), 32'd0);

    // Zero-wait non-memory stream: commit every 4th cycle
    rst = 1'b0; run = 1'b1; imem_ready = 1'b1; imem_data = 16'h1000;
    step();
    chk("t1_fetch_state", 32'(state), 32'd1);
    chk("t1_imem_req", 32'(imem_req), 32'd1);
    chk("t1_halted", 32'(halted), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i % 4 == 3) begin
        chk("t1_commit", 32'(commit), 32'd1);
        chk("t1_commit_pc", 32'(pc), 32'(i / 4));
      end else begin
        chk("t1_no_commit", 32'(commit), 32'd0);
      end
    end
    chk("t1_retired", 32'(retired), 32'd4);
    chk("t1_pc", 32'(pc), 32'd4);
    chk("t1_state", 32'(state), 32'd1);

    // Fetch wait at pc=5
    step(); step(); step(); step();
    chk("t2_pc5", 32'(pc), 32'd5);
    chk("t2_fetch", 32'(state), 32'd1);
    imem_ready = 1'b0;
    step();
    chk("t2_req_c2", 32'(imem_req), 32'd1);
    chk("t2_addr_c2", 32'(imem_addr), 32'd5);
    step();
    chk("t2_req_c3", 32'(imem_req), 32'd1);
    chk("t2_instr_held", 32'(instruction), 32'h1000);
    step();
    chk("t2_req_c4", 32'(imem_req), 32'd1);
    chk("t2_addr_c4", 32'(imem_addr), 32'd5);
    imem_ready = 1'b1; imem_data = 16'h2345;
    step();
    chk("t2_decode", 32'(state), 32'd2);
    chk("t2_req_drop", 32'(imem_req), 32'd0);
    chk("t2_instr", 32'(instruction), 32'h2345);
    step();
    chk("t2_exec", 32'(state), 32'd3);
    step();
    chk("t2_commit", 32'(commit), 32'd1);
    step();
    chk("t2_commit_once", 32'(commit), 32'd0);
    chk("t2_pc6", 32'(pc), 32'd6);

    // Memory op with ack on third MEM cycle
    imem_data = 16'h0801;
    step();
    chk("t3_instr", 32'(instruction), 32'h0801);
    step();
    chk("t3_exec", 32'(state), 32'd3);
    step();
    chk("t3_mem_req1", 32'(mem_req), 32'd1);
    chk("t3_mem_state", 32'(state), 32'd4);
    step();
    chk("t3_mem_req2", 32'(mem_req), 32'd1);
    step();
    chk("t3_mem_req3", 32'(mem_req), 32'd1);
    chk("t3_no_commit", 32'(commit), 32'd0);
    mem_ack = 1'b1;
    step();
    chk("t3_commit", 32'(commit), 32'd1);
    chk("t3_mem_req_drop", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    step();
    chk("t3_pc7", 32'(pc), 32'd7);
    chk("t3_retired", 32'(retired), 32'd7);

    // Jump to FFFF then wrap; jump inputs outside COMMIT are ignored
    imem_data = 16'h1000;
    step();
    jump_valid = 1'b1; jump_target = 16'h1234;
    step(); step();
    chk("t4_commit", 32'(commit), 32'd1);
    jump_target = 16'hFFFF;
    step();
    chk("t4_pc_jump", 32'(pc), 32'hFFFF);
    chk("t4_addr_jump", 32'(imem_addr), 32'hFFFF);
    jump_valid = 1'b0;
    step(); step(); step(); step();
    chk("t4_pc_wrap", 32'(pc), 32'h0000);
    chk("t4_retired", 32'(retired), 32'd9);

    // run dropped during DECODE at pc=2
    for (int i = 0; i < 8; i++) step();
    chk("t5_pc2", 32'(pc), 32'd2);
    step();
    chk("t5_decode", 32'(state), 32'd2);
    run = 1'b0;
    step(); step();
    chk("t5_commit", 32'(commit), 32'd1);
    step();
    chk("t5_pc3", 32'(pc), 32'd3);
    chk("t5_idle", 32'(state), 32'd0);
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_retired", 32'(retired), 32'd12);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_imem_req", 32'(imem_req), 32'd0);
    end

    // Memory timeout -> FAULT after 4 MEM cycles
    run = 1'b1; imem_data = 16'h0801;
    step(); step(); step(); step();
    chk("t6_mem1", 32'(state), 32'd4);
    step(); step(); step();
    chk("t6_mem4", 32'(state), 32'd4);
    chk("t6_mem4_req", 32'(mem_req), 32'd1);
    step();
    chk("t6_fault_state", 32'(state), 32'd6);
    chk("t6_fault", 32'(fault), 32'd1);
    chk("t6_mem_req_off", 32'(mem_req), 32'd0);
    chk("t6_pc_frozen", 32'(pc), 32'd3);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_stuck", 32'(state), 32'd6);
      chk("t6_no_commit", 32'(commit), 32'd0);
      chk("t6_no_imem_req", 32'(imem_req), 32'd0);
    end
    mem_ack = 1'b0;
    chk("t6_retired_frozen", 32'(retired), 32'd12);
    rst = 1'b1;
    step();
    chk("t6_rst_fault", 32'(fault), 32'd0);
    chk("t6_rst_pc", 32'(pc), 32'd0);
    chk("t6_rst_state", 32'(state), 32'd0);
    rst = 1'b0;

    // Ack on the limit cycle wins, then rst in MEM
    step(); step(); step(); step(); step(); step(); step();
    chk("t7_mem4", 32'(state), 32'd4);
    mem_ack = 1'b1;
    step();
    chk("t7_ack_wins", 32'(commit), 32'd1);
    chk("t7_no_fault", 32'(fault), 32'd0);
    mem_ack = 1'b0;
    step();
    chk("t7_pc1", 32'(pc), 32'd1);
    step(); step(); step(); step();
    chk("t7_in_mem", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    chk("t7_rst_idle", 32'(state), 32'd0);
    chk("t7_rst_mem_req", 32'(mem_req), 32'd0);
    chk("t7_rst_pc", 32'(pc), 32'd0);
    chk("t7_rst_instr", 32'(instruction), 32'h0);
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
